// File: rtl/ram_pkg.sv
// Shared types for the two-port RAM arbiter: owner state encoding and the
// read-return tag that follows an accepted read through the RAM latency.
package ram_pkg;

   localparam int AW_DEF = 18;
   localparam int DW_DEF = 32;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } own_state_t;

   typedef struct packed {
      logic valid;
      logic port;
   } rd_tag_t;

   function automatic own_state_t own_of(input logic port);
      return port ? OWN1 : OWN0;
   endfunction

endpackage

// File: rtl/ram_arb_if.sv
// Requester and RAM-side signal bundle for ram_arb; slave is the arbiter view,
// master is the requester/RAM-model view.
interface ram_arb_if
   import ram_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
);
   logic          req0;
   logic          we0;
   logic [AW-1:0] addr0;
   logic [DW-1:0] wdata0;
   logic          gnt0;
   logic          rvalid0;

   logic          req1;
   logic          we1;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata1;
   logic          gnt1;
   logic          rvalid1;

   logic [DW-1:0] rdata;

   logic          ram_cs;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;

   modport slave (
      input  req0, we0, addr0, wdata0,
      input  req1, we1, addr1, wdata1,
      output gnt0, rvalid0, gnt1, rvalid1, rdata,
      output ram_cs, ram_we, ram_addr, ram_wdata,
      input  ram_rdata
   );

   modport master (
      output req0, we0, addr0, wdata0,
      output req1, we1, addr1, wdata1,
      input  gnt0, rvalid0, gnt1, rvalid1, rdata,
      input  ram_cs, ram_we, ram_addr, ram_wdata,
      output ram_rdata
   );
endinterface

// File: rtl/ram_rd_tag_pipe.sv
// RD_LAT-deep shift register of read tags, aligned with the RAM read latency;
// synchronous clear drops every in-flight tag.
module ram_rd_tag_pipe
   import ram_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic    hclk,
   input  logic    hreset,
   input  rd_tag_t tag_p0,
   output rd_tag_t tag_out
);

   rd_tag_t tag_pn [RD_LAT];

   always_ff @(posedge hclk) begin
      if (hreset) begin
         for (int i = 0; i < RD_LAT; i++) tag_pn[i] <= '0;
      end else begin
         tag_pn[0] <= tag_p0;
         for (int i = 1; i < RD_LAT; i++) tag_pn[i] <= tag_pn[i-1];
      end
   end

   assign tag_out = tag_pn[RD_LAT-1];

endmodule

// File: rtl/ram_arb.sv
// Round-robin arbiter with bounded burst hold for a single-port word RAM shared
// by two requesters; read data is routed back via a latency-matched tag pipe.
module ram_arb
   import ram_pkg::*;
#(
   parameter int AW        = AW_DEF,
   parameter int DW        = DW_DEF,
   parameter int RD_LAT    = 1,
   parameter int MAX_BURST = 4
) (
   input  logic    hclk,
   input  logic    hreset,
   ram_arb_if.slave bus
);

   localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

   own_state_t state;
   logic       last;
   logic [3:0] burst_cnt;

   logic       win_vld;
   logic       win_port;
   rd_tag_t    tag_p0;
   rd_tag_t    tag_out;

   // Grant decision: an owner under contention keeps the RAM until its burst runs out.
   always_comb begin
      win_vld  = 1'b0;
      win_port = 1'b0;
      if (!hreset) begin
         if (bus.req0 && bus.req1) begin
            win_vld = 1'b1;
            case (state)
               OWN0:    win_port = (burst_cnt < MAX_CNT) ? 1'b0 : 1'b1;
               OWN1:    win_port = (burst_cnt < MAX_CNT) ? 1'b1 : 1'b0;
               default: win_port = ~last;
            endcase
         end else if (bus.req0) begin
            win_vld  = 1'b1;
            win_port = 1'b0;
         end else if (bus.req1) begin
            win_vld  = 1'b1;
            win_port = 1'b1;
         end
      end
   end

   assign bus.gnt0      = win_vld & ~win_port;
   assign bus.gnt1      = win_vld &  win_port;
   assign bus.ram_cs    = win_vld;
   assign bus.ram_we    = win_vld & (win_port ? bus.we1 : bus.we0);
   assign bus.ram_addr  = win_vld ? (win_port ? bus.addr1  : bus.addr0)  : '0;
   assign bus.ram_wdata = win_vld ? (win_port ? bus.wdata1 : bus.wdata0) : '0;

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state     <= IDLE;
         last      <= 1'b1;
         burst_cnt <= '0;
      end else if (win_vld) begin
         state <= own_of(win_port);
         last  <= win_port;
         if (state == own_of(win_port))
            burst_cnt <= (burst_cnt == MAX_CNT) ? burst_cnt : burst_cnt + 4'd1;
         else
            burst_cnt <= 4'd1;
      end else begin
         state     <= IDLE;
         burst_cnt <= '0;
      end
   end

   // Read return: tag enters with the RAM access and exits with ram_rdata.
   always_comb begin
      tag_p0       = '0;
      tag_p0.valid = win_vld & ~bus.ram_we;
      tag_p0.port  = win_port;
   end

   ram_rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
      .hclk    (hclk),
      .hreset  (hreset),
      .tag_p0  (tag_p0),
      .tag_out (tag_out)
   );

   assign bus.rvalid0 = ~hreset & tag_out.valid & ~tag_out.port;
   assign bus.rvalid1 = ~hreset & tag_out.valid &  tag_out.port;
   assign bus.rdata   = bus.ram_rdata;

endmodule

// File: tb/tb_ram_arb.sv
// Directed bench for ram_arb: vector table on a RD_LAT=1/MAX_BURST=4 instance
// plus hand sequences, and an interleave check on a RD_LAT=2/MAX_BURST=1 instance.
module tb_ram_arb;
   import ram_pkg::*;

   localparam int AW = 18;
   localparam int DW = 32;

   logic hclk = 1'b0;
   always #5 hclk = ~hclk;

   logic hreset_a;
   logic hreset_b;

   ram_arb_if #(.AW(AW), .DW(DW)) bus_a ();
   ram_arb_if #(.AW(AW), .DW(DW)) bus_b ();

   ram_arb #(.AW(AW), .DW(DW), .RD_LAT(1), .MAX_BURST(4)) dut_a (
      .hclk(hclk), .hreset(hreset_a), .bus(bus_a.slave));
   ram_arb #(.AW(AW), .DW(DW), .RD_LAT(2), .MAX_BURST(1)) dut_b (
      .hclk(hclk), .hreset(hreset_b), .bus(bus_b.slave));

   // RAM models, one per instance, with matching read latency
   logic [DW-1:0] mem_a [0:(1<<AW)-1];
   logic [DW-1:0] mem_b [0:(1<<AW)-1];
   logic          pl_we;
   logic [AW-1:0] pl_addr;
   logic [DW-1:0] pl_data;
   logic [DW-1:0] rd_a_q, rd_b_q1, rd_b_q2;

   always @(posedge hclk) begin
      if (pl_we) begin
         mem_a[pl_addr] <= pl_data;
         mem_b[pl_addr] <= pl_data;
      end else begin
         if (bus_a.ram_cs && bus_a.ram_we) mem_a[bus_a.ram_addr] <= bus_a.ram_wdata;
         if (bus_b.ram_cs && bus_b.ram_we) mem_b[bus_b.ram_addr] <= bus_b.ram_wdata;
      end
      rd_a_q  <= (bus_a.ram_cs && !bus_a.ram_we) ? mem_a[bus_a.ram_addr] : 32'hBAD0_0000;
      rd_b_q1 <= (bus_b.ram_cs && !bus_b.ram_we) ? mem_b[bus_b.ram_addr] : 32'hBAD0_0001;
      rd_b_q2 <= rd_b_q1;
   end

   assign bus_a.ram_rdata = rd_a_q;
   assign bus_b.ram_rdata = rd_b_q2;

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic          rst;
      logic          req0, we0;
      logic [AW-1:0] addr0;
      logic [DW-1:0] wdata0;
      logic          req1, we1;
      logic [AW-1:0] addr1;
      logic [DW-1:0] wdata1;
      logic          g0, g1, cs, we;
      logic [AW-1:0] ra;
      logic [DW-1:0] wd;
      logic          rv0, rv1;
      logic [DW-1:0] rd;
   } vec_t;

   vec_t vecs [$];

   function automatic vec_t mk(
      input logic rst,
      input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
      input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
      input logic g0, input logic g1, input logic cs, input logic we,
      input logic [AW-1:0] ra, input logic [DW-1:0] wd,
      input logic rv0, input logic rv1, input logic [DW-1:0] rd);
      vec_t v;
      v.rst = rst; v.req0 = r0; v.we0 = w0; v.addr0 = a0; v.wdata0 = d0;
      v.req1 = r1; v.we1 = w1; v.addr1 = a1; v.wdata1 = d1;
      v.g0 = g0; v.g1 = g1; v.cs = cs; v.we = we; v.ra = ra; v.wd = wd;
      v.rv0 = rv0; v.rv1 = rv1; v.rd = rd;
      return v;
   endfunction

   task automatic drive_a(input logic r0, input logic w0, input logic [AW-1:0] a0,
                          input logic [DW-1:0] d0, input logic r1, input logic w1,
                          input logic [AW-1:0] a1, input logic [DW-1:0] d1);
      bus_a.req0 = r0; bus_a.we0 = w0; bus_a.addr0 = a0; bus_a.wdata0 = d0;
      bus_a.req1 = r1; bus_a.we1 = w1; bus_a.addr1 = a1; bus_a.wdata1 = d1;
   endtask

   task automatic drive_b(input logic r0, input logic [AW-1:0] a0,
                          input logic r1, input logic [AW-1:0] a1);
      bus_b.req0 = r0; bus_b.we0 = 1'b0; bus_b.addr0 = a0; bus_b.wdata0 = '0;
      bus_b.req1 = r1; bus_b.we1 = 1'b0; bus_b.addr1 = a1; bus_b.wdata1 = '0;
   endtask

   initial begin
      hreset_a = 1'b1;
      hreset_b = 1'b1;
      drive_a(0, 0, '0, '0, 0, 0, '0, '0);
      drive_b(0, '0, 0, '0);

      // preload RAM contents while both instances sit in reset
      pl_we = 1'b1; pl_addr = 18'h00010; pl_data = 32'hDEADBEEF;
      @(posedge hclk); #1;
      pl_addr = 18'h00001; pl_data = 32'h11111111;
      @(posedge hclk); #1;
      pl_addr = 18'h00002; pl_data = 32'h22222222;
      @(posedge hclk); #1;
      pl_we = 1'b0;

      //         rst r0 w0 a0        d0  r1 w1 a1        d1           g0 g1 cs we ra        wd            rv0 rv1 rd
      vecs.push_back(mk(1, 1,0,18'h10,   0, 1,0,18'h2,    0,           0,0,0,0,18'h0,    0,            0,0,0));
      vecs.push_back(mk(0, 1,0,18'h10,   0, 0,0,18'h0,    0,           1,0,1,0,18'h10,   0,            0,0,0));
      vecs.push_back(mk(0, 0,0,18'h0,    0, 0,0,18'h0,    0,           0,0,0,0,18'h0,    0,            1,0,32'hDEADBEEF));
      vecs.push_back(mk(0, 0,0,18'h0,    0, 0,0,18'h0,    0,           0,0,0,0,18'h0,    0,            0,0,0));
      vecs.push_back(mk(1, 0,0,18'h0,    0, 0,0,18'h0,    0,           0,0,0,0,18'h0,    0,            0,0,0));
      vecs.push_back(mk(0, 1,0,18'h1,    0, 1,0,18'h2,    0,           1,0,1,0,18'h1,    0,            0,0,0));
      vecs.push_back(mk(0, 1,0,18'h1,    0, 1,0,18'h2,    0,           1,0,1,0,18'h1,    0,            1,0,32'h11111111));
      vecs.push_back(mk(0, 1,0,18'h1,    0, 1,0,18'h2,    0,           1,0,1,0,18'h1,    0,            1,0,32'h11111111));
      vecs.push_back(mk(0, 1,0,18'h1,    0, 1,0,18'h2,    0,           1,0,1,0,18'h1,    0,            1,0,32'h11111111));
      vecs.push_back(mk(0, 1,0,18'h1,    0, 1,0,18'h2,    0,           0,1,1,0,18'h2,    0,            1,0,32'h11111111));
      vecs.push_back(mk(0, 1,0,18'h1,    0, 1,0,18'h2,    0,           0,1,1,0,18'h2,    0,            0,1,32'h22222222));
      vecs.push_back(mk(0, 1,0,18'h1,    0, 1,0,18'h2,    0,           0,1,1,0,18'h2,    0,            0,1,32'h22222222));
      vecs.push_back(mk(0, 1,0,18'h1,    0, 1,0,18'h2,    0,           0,1,1,0,18'h2,    0,            0,1,32'h22222222));
      vecs.push_back(mk(0, 1,0,18'h1,    0, 1,0,18'h2,    0,           1,0,1,0,18'h1,    0,            0,1,32'h22222222));
      vecs.push_back(mk(0, 0,0,18'h0,    0, 0,0,18'h0,    0,           0,0,0,0,18'h0,    0,            1,0,32'h11111111));
      vecs.push_back(mk(0, 0,0,18'h0,    0, 0,0,18'h0,    0,           0,0,0,0,18'h0,    0,            0,0,0));
      vecs.push_back(mk(0, 0,0,18'h0,    0, 1,1,18'h3FFFF,32'h0000A5A5, 0,1,1,1,18'h3FFFF,32'h0000A5A5, 0,0,0));
      vecs.push_back(mk(0, 1,0,18'h3FFFF,0, 0,0,18'h0,    0,           1,0,1,0,18'h3FFFF,0,            0,0,0));
      vecs.push_back(mk(0, 0,0,18'h0,    0, 0,0,18'h0,    0,           0,0,0,0,18'h0,    0,            1,0,32'h0000A5A5));

      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge hclk); #1;
         hreset_a = vecs[i].rst;
         drive_a(vecs[i].req0, vecs[i].we0, vecs[i].addr0, vecs[i].wdata0,
                 vecs[i].req1, vecs[i].we1, vecs[i].addr1, vecs[i].wdata1);
         @(negedge hclk);
         check($sformatf("v%0d gnt0", i),      32'(bus_a.gnt0),      32'(vecs[i].g0));
         check($sformatf("v%0d gnt1", i),      32'(bus_a.gnt1),      32'(vecs[i].g1));
         check($sformatf("v%0d ram_cs", i),    32'(bus_a.ram_cs),    32'(vecs[i].cs));
         check($sformatf("v%0d ram_we", i),    32'(bus_a.ram_we),    32'(vecs[i].we));
         check($sformatf("v%0d ram_addr", i),  32'(bus_a.ram_addr),  32'(vecs[i].ra));
         check($sformatf("v%0d ram_wdata", i), bus_a.ram_wdata,      vecs[i].wd);
         check($sformatf("v%0d rvalid0", i),   32'(bus_a.rvalid0),   32'(vecs[i].rv0));
         check($sformatf("v%0d rvalid1", i),   32'(bus_a.rvalid1),   32'(vecs[i].rv1));
         if (vecs[i].rv0 || vecs[i].rv1)
            check($sformatf("v%0d rdata", i), bus_a.rdata, vecs[i].rd);
      end

      // uncontended streaming on port 1, then port 0 joins after the burst saturated
      @(posedge hclk); #1;
      hreset_a = 1'b1;
      drive_a(0, 0, '0, '0, 0, 0, '0, '0);
      @(posedge hclk); #1;
      hreset_a = 1'b0;
      drive_a(0, 0, '0, '0, 1, 0, 18'h2, '0);
      for (int c = 0; c < 20; c++) begin
         @(negedge hclk);
         check($sformatf("stream%0d gnt1", c), 32'(bus_a.gnt1), 32'd1);
         check($sformatf("stream%0d gnt0", c), 32'(bus_a.gnt0), 32'd0);
         @(posedge hclk); #1;
      end
      check("stream burst_cnt", 32'(dut_a.burst_cnt), 32'd4);
      drive_a(1, 0, 18'h1, '0, 1, 0, 18'h2, '0);
      @(negedge hclk);
      check("stream handoff gnt0", 32'(bus_a.gnt0), 32'd1);
      check("stream handoff gnt1", 32'(bus_a.gnt1), 32'd0);

      // reset lands while a read is in flight
      @(posedge hclk); #1;
      drive_a(0, 0, '0, '0, 0, 0, '0, '0);
      @(posedge hclk); #1;
      drive_a(1, 0, 18'h10, '0, 0, 0, '0, '0);
      @(negedge hclk);
      check("midrst accept gnt0", 32'(bus_a.gnt0), 32'd1);
      @(posedge hclk); #1;
      hreset_a = 1'b1;
      drive_a(1, 0, 18'h10, '0, 1, 0, 18'h2, '0);
      @(negedge hclk);
      check("midrst gnt0",    32'(bus_a.gnt0),    32'd0);
      check("midrst gnt1",    32'(bus_a.gnt1),    32'd0);
      check("midrst ram_cs",  32'(bus_a.ram_cs),  32'd0);
      check("midrst rvalid0", 32'(bus_a.rvalid0), 32'd0);
      check("midrst rvalid1", 32'(bus_a.rvalid1), 32'd0);
      @(posedge hclk); #1;
      hreset_a = 1'b0;
      @(negedge hclk);
      check("postrst rvalid0", 32'(bus_a.rvalid0), 32'd0);
      check("postrst rvalid1", 32'(bus_a.rvalid1), 32'd0);
      check("postrst gnt0",    32'(bus_a.gnt0),    32'd1);
      check("postrst gnt1",    32'(bus_a.gnt1),    32'd0);
      @(posedge hclk); #1;
      drive_a(0, 0, '0, '0, 0, 0, '0, '0);

      // alternating contended reads on the RD_LAT=2, MAX_BURST=1 instance
      hreset_b = 1'b0;
      for (int c = 0; c < 12; c++) begin
         drive_b(c < 10, 18'h1, c < 10, 18'h2);
         @(negedge hclk);
         check($sformatf("ilv%0d gnt0", c), 32'(bus_b.gnt0), (c < 10 && c % 2 == 0) ? 32'd1 : 32'd0);
         check($sformatf("ilv%0d gnt1", c), 32'(bus_b.gnt1), (c < 10 && c % 2 == 1) ? 32'd1 : 32'd0);
         check($sformatf("ilv%0d rvalid0", c), 32'(bus_b.rvalid0), (c >= 2 && c % 2 == 0) ? 32'd1 : 32'd0);
         check($sformatf("ilv%0d rvalid1", c), 32'(bus_b.rvalid1), (c >= 2 && c % 2 == 1) ? 32'd1 : 32'd0);
         if (c >= 2)
            check($sformatf("ilv%0d rdata", c), bus_b.rdata,
                  (c % 2 == 0) ? 32'h11111111 : 32'h22222222);
         @(posedge hclk); #1;
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/ram_arb.md
Name: ram_arb

Overview:
- Two-requester arbiter for the single-port 32-bit word RAM behind the AHB RAM slave interface.
- Requester 0 is the AHB-side RAM interface; requester 1 is a secondary master such as a DMA or test engine.
- Sequences one access per cycle onto the RAM and routes read data back to the owner with the correct latency.
- Uses round-robin arbitration with a bounded burst hold, so neither side starves.

Parameters:
- AW, 18, RAM word-address width (byte address bits [19:2]).
- DW, 32, data width.
- RD_LAT, 1, RAM read latency in cycles, from ram_cs+!ram_we to valid ram_rdata; legal values 1..4.
- MAX_BURST, 4, maximum consecutive accepted cycles an owner may hold the RAM while the other port is requesting; legal values 1..15.

Ports:
- hclk  in  1  clock; all logic on rising edge.
- hreset  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 access request.
- we0  in  1  requester 0 write (1) / read (0).
- addr0  in  AW  requester 0 word address.
- wdata0  in  DW  requester 0 write data.
- gnt0  out  1  requester 0 access accepted this cycle.
- rvalid0  out  1  read data valid for requester 0.
- req1, we1, addr1, wdata1, gnt1, rvalid1: same as port 0, for requester 1.
- rdata  out  DW  read data, shared by both ports; qualified only by rvalidN.
- ram_cs  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  AW  RAM word address.
- ram_wdata  out  DW  RAM write data.
- ram_rdata  in  DW  RAM read data.

Behaviour:
- Reset is synchronous and active-high: hreset sampled high at a rising edge of hclk resets the block; the clock is hclk.
- Reset values:
  - state = IDLE, last = 1 (so port 0 wins the first contention), burst_cnt = 0.
  - Read tag pipeline cleared; rvalid0 = rvalid1 = 0.
  - While hreset is high, gnt0 = gnt1 = 0 and ram_cs = 0 regardless of req.
- States:
  - IDLE: no owner.
  - OWN0, OWN1: the named port owns the RAM.
  - Registered owner holds the state.
- Grant decision (combinational, same cycle as req):
  - Only req0 high: gnt0 = 1.
  - Only req1 high: gnt1 = 1.
  - Both high in IDLE: the port != last wins.
  - Both high in OWNn: n keeps the grant while burst_cnt < MAX_BURST, otherwise the other port wins.
  - At most one gnt is high per cycle; gntN never rises without reqN.
- Transfer: an access is accepted when reqN & gntN.
  - ram_cs = 1; ram_we/ram_addr/ram_wdata are muxed from the winner in the same cycle (zero-latency path).
  - No winner: ram_cs = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0.
- State update at each edge:
  - Winner n: state <= OWNn and last <= n.
  - burst_cnt <= burst_cnt + 1 (saturating at MAX_BURST) if n was already the owner, else burst_cnt <= 1.
  - No request: state <= IDLE and burst_cnt <= 0; last is kept.
- burst_cnt only limits ownership while the other port requests. An uncontended owner is granted every cycle indefinitely.
- Read return:
  - An accepted read pushes tag {valid=1, port=n} into an RD_LAT-deep shift register; writes push valid=0.
  - At the pipeline output, rvalidN = valid & (port == N), and rdata = ram_rdata passed through combinationally.
  - Back-to-back reads from alternating ports return in issue order, one per cycle.
- Writes produce no response; a write is complete on acceptance.
- Reset mid-operation: in-flight read tags are discarded and no rvalid is produced for them. Requesters must reissue.
- Requesters must hold req/we/addr/wdata stable until gnt is seen. The arbiter does not register request fields.

Decomposition:
- Shared package ram_pkg: AW/DW defaults; owner state encoding IDLE=2'b00, OWN0=2'b01, OWN1=2'b10; tag struct {valid, port}.
- One natural sub-module, ram_rd_tag_pipe: parameterised RD_LAT shift register of tags with synchronous clear.

Test Plan:
- Reset then single read: req0 = 1, we0 = 0, addr0 = 0x00010 with RAM preloaded 0xDEADBEEF at that address.
  Required: gnt0 = 1 that cycle; rvalid0 = 1 with rdata = 0xDEADBEEF exactly RD_LAT cycles later; rvalid1 stays 0.
- Simultaneous first request: req0 = req1 = 1 from IDLE after reset.
  Required: gnt0 wins first; with both held high and MAX_BURST = 4, grants run 0,0,0,0,1,1,1,1,0...
- Uncontended streaming: req1 held high for 20 cycles with req0 = 0.
  Required: gnt1 = 1 on all 20 cycles and burst_cnt saturates at 4.
- Interleaved reads with RD_LAT = 2 and MAX_BURST = 1: alternating contended reads to addr0 = 0x1 and addr1 = 0x2, holding 0x11111111 and 0x22222222.
  Required: rvalid0/rvalid1 alternate with matching data, in order, every cycle.
- Write then read: port 1 writes 0x0000A5A5 to 0x3FFFF (top address); port 0 then reads 0x3FFFF.
  Required: rdata = 0x0000A5A5 and ram_addr = 18'h3FFFF, with no wrap.
- Reset mid-read: accept a read, then assert hreset on the next edge.
  Required: no rvalid on either port, gnt = 0 during reset, and the first contended access after reset goes to port 0.
